// File: rtl/half_precision_div_if.sv
// half_precision_div_if: operand/result handshake bundle for the binary16 divider
// master: drives in_valid, a, b, out_ready (operand source / result consumer)
// slave:  drives in_ready, out_valid, p and the one-hot class flags (divider side)
// HP_DIV_INEXACT_EN adds the inexact result flag
interface half_precision_div_if;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, p;
  logic snan, qnan, infinity, zero, subnormal, normal;
`ifdef HP_DIV_INEXACT_EN
  logic inexact;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, snan, qnan, infinity, zero, subnormal, normal, inexact);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, snan, qnan, infinity, zero, subnormal, normal, inexact);
`else
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, snan, qnan, infinity, zero, subnormal, normal);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, snan, qnan, infinity, zero, subnormal, normal);
`endif
endinterface

// File: rtl/half_precision_div.sv
// half_precision_div: sequential IEEE-754 binary16 divider p = a / b, truncating
// clk, rst_n (async active-low); bus (slave): in_valid/in_ready/a/b accept operands in IDLE,
// out_valid/out_ready/p/class flags return the result held stable in DONE.
// HP_DIV_INEXACT_EN adds bus.inexact. Special operands finish in 1 edge, others in 14.
module half_precision_div #(
  parameter int N = 16,
  parameter int QBITS = 12,
  parameter logic [9:0] QNAN_MAN = 10'h200
) (
  input logic clk,
  input logic rst_n,
  half_precision_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
  state_t state, state_n;
  logic sign, sgn, spec, ge;
  logic [11:0] rem, q;
  logic [10:0] mb, man;
  logic [9:0] sub_man;
  logic [3:0] count, sh;
  logic signed [6:0] qe, ea, eb, e;
  logic [N-1:0] p_r, sp_p, pk_p;
  logic [5:0] cls, sp_cls, pk_cls;
  logic a_zero, b_zero, a_inf, b_inf, a_snan, b_snan, a_qnan, b_qnan;
  // subnormal operands have a zero exponent field and are flushed to signed zero
  assign a_zero = bus.a[14:10] == 5'h0;
  assign b_zero = bus.b[14:10] == 5'h0;
  assign a_inf = &bus.a[14:10] && bus.a[9:0] == 10'h0;
  assign b_inf = &bus.b[14:10] && bus.b[9:0] == 10'h0;
  assign a_snan = &bus.a[14:10] && bus.a[9:0] != 10'h0 && !bus.a[9];
  assign b_snan = &bus.b[14:10] && bus.b[9:0] != 10'h0 && !bus.b[9];
  assign a_qnan = &bus.a[14:10] && bus.a[9];
  assign b_qnan = &bus.b[14:10] && bus.b[9];
  assign sgn = bus.a[15] ^ bus.b[15];
  assign ea = $signed({2'b0, bus.a[14:10]}) - 7'sd15;
  assign eb = $signed({2'b0, bus.b[14:10]}) - 7'sd15;
  assign spec = &bus.a[14:10] || &bus.b[14:10] || a_zero || b_zero;
  // special-case priority: sNaN, qNaN, invalid (inf/inf, 0/0), infinity, zero
  always_comb begin
    sp_p = a_snan ? bus.a : b_snan ? bus.b : a_qnan ? bus.a : b_qnan ? bus.b :
           ((a_inf && b_inf) || (a_zero && b_zero)) ? {sgn, 5'h1F, QNAN_MAN} :
           (a_inf || b_zero) ? {sgn, 5'h1F, 10'h0} : {sgn, 15'h0};
    sp_cls = (a_snan || b_snan) ? 6'b100000 : (a_qnan || b_qnan) ? 6'b010000 :
             ((a_inf && b_inf) || (a_zero && b_zero)) ? 6'b010000 :
             (a_inf || b_zero) ? 6'b001000 : 6'b000100;
  end
  assign ge = rem >= {1'b0, mb};
  // a quotient below 1.0 leaves its leading one at q[10], one exponent lower
  assign man = q[11] ? q[11:1] : q[10:0];
  assign e = q[11] ? qe : qe - 7'sd1;
  assign sh = 4'(-7'sd14 - e);
  assign sub_man = 10'(man >> sh);
  always_comb begin
    pk_p = e > 7'sd15 ? {sign, 15'h7C00} : e < -7'sd24 ? {sign, 15'h0} :
           e < -7'sd14 ? {sign, 5'h0, sub_man} : {sign, 5'(e + 7'sd15), man[9:0]};
    pk_cls = e > 7'sd15 ? 6'b001000 : e < -7'sd24 ? 6'b000100 : e < -7'sd14 ? 6'b000010 : 6'b000001;
  end
`ifdef HP_DIV_INEXACT_EN
  logic inexact, pk_inx;
  assign pk_inx = (e > 7'sd15 || e < -7'sd24) ? 1'b1 :
                  rem != 12'h0 || (q[11] && q[0]) || (e < -7'sd14 && |(man & ~(11'h7FF << sh)));
  assign bus.inexact = inexact;
`endif
  always_comb
    state_n = state == IDLE ? (bus.in_valid ? (spec ? DONE : DIV) : IDLE) :
              state == DIV ? (count == 4'd0 ? PACK : DIV) :
              state == PACK ? DONE : (bus.out_ready ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sign <= 1'b0;
      rem <= '0;
      q <= '0;
      mb <= '0;
      qe <= '0;
      count <= '0;
      p_r <= '0;
      cls <= '0;
`ifdef HP_DIV_INEXACT_EN
      inexact <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        sign <= sgn;
        rem <= {1'b0, 1'b1, bus.a[9:0]};
        mb <= {1'b1, bus.b[9:0]};
        q <= '0;
        qe <= ea - eb;
        count <= 4'(QBITS - 1);
        if (spec) begin
          p_r <= sp_p;
          cls <= sp_cls;
`ifdef HP_DIV_INEXACT_EN
          inexact <= 1'b0;
`endif
        end
      end
      if (state == DIV) begin
        q <= {q[10:0], ge};
        rem <= (ge ? rem - {1'b0, mb} : rem) << 1;
        count <= count - 4'd1;
      end
      if (state == PACK) begin
        p_r <= pk_p;
        cls <= pk_cls;
`ifdef HP_DIV_INEXACT_EN
        inexact <= pk_inx;
`endif
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.p = p_r;
  assign {bus.snan, bus.qnan, bus.infinity, bus.zero, bus.subnormal, bus.normal} = cls;
endmodule
